// File: rtl/game_cmd_uart_rx.sv
// UART (8N1) command front-end for the countdown stage: receives 'S' <time> <chk>
// start frames and 'X' abort bytes. It drives timing/start/abort/cmd_err.
module game_cmd_uart_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int MAX_TIME     = 99,
  parameter int TIMEOUT_CYC  = 50000000
) (
  input  logic       basys_clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       game_active,
  output logic [6:0] timing,
  output logic       start,
  output logic       abort,
  output logic       cmd_err
);

  localparam int CLK_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rxState_e;
  typedef enum logic [1:0] {P_IDLE, P_VAL, P_CHK} parseState_e;

  logic             rxMeta_q;
  logic             rxSync_q;
  rxState_e         rState_q;
  logic [CLK_W-1:0] clkCnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic [7:0]       byte_q;
  logic             byteValid_q;
  logic             frameErr_q;
  parseState_e      pState_q;
  logic [7:0]       val_q;
  logic [TO_W-1:0]  toCnt_q;
  logic [6:0]       timing_q;
  logic             start_q;
  logic             abort_q;
  logic             cmdErr_q;
  logic             frameOk_d;

  // The line idles high, so the synchronizer resets to 1 and does not fake a start bit.
  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rState_q    <= R_IDLE;
      clkCnt_q    <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (rState_q)
        R_IDLE: begin
          clkCnt_q <= '0;
          bitIdx_q <= '0;
          if (!rxSync_q) rState_q <= R_START;
        end
        // Re-check the start bit at its centre so short glitches are ignored.
        R_START: begin
          if (clkCnt_q == CLK_W'(CLKS_PER_BIT / 2 - 1)) begin
            clkCnt_q <= '0;
            rState_q <= rxSync_q ? R_IDLE : R_DATA;
          end else begin
            clkCnt_q <= clkCnt_q + CLK_W'(1);
          end
        end
        R_DATA: begin
          if (clkCnt_q == CLK_W'(CLKS_PER_BIT - 1)) begin
            clkCnt_q <= '0;
            shift_q  <= {rxSync_q, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) rState_q <= R_STOP;
          end else begin
            clkCnt_q <= clkCnt_q + CLK_W'(1);
          end
        end
        R_STOP: begin
          if (clkCnt_q == CLK_W'(CLKS_PER_BIT - 1)) begin
            clkCnt_q <= '0;
            rState_q <= R_IDLE;
            if (rxSync_q) begin
              byte_q      <= shift_q;
              byteValid_q <= 1'b1;
            end else begin
              frameErr_q  <= 1'b1;
            end
          end else begin
            clkCnt_q <= clkCnt_q + CLK_W'(1);
          end
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  assign frameOk_d = (byte_q == (8'h53 ^ val_q)) && (val_q != 8'd0) &&
                     (val_q <= 8'(MAX_TIME)) && !game_active;

  // A framing error outranks everything else, so it never stacks with a timeout.
  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pState_q <= P_IDLE;
      val_q    <= '0;
      toCnt_q  <= '0;
      timing_q <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      cmdErr_q <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      cmdErr_q <= 1'b0;
      if (frameErr_q) begin
        pState_q <= P_IDLE;
        toCnt_q  <= '0;
        cmdErr_q <= 1'b1;
      end else if (byteValid_q) begin
        toCnt_q <= '0;
        case (pState_q)
          P_IDLE: begin
            if (byte_q == 8'h53)      pState_q <= P_VAL;
            else if (byte_q == 8'h58) abort_q  <= 1'b1;
            else                      cmdErr_q <= 1'b1;
          end
          P_VAL: begin
            val_q    <= byte_q;
            pState_q <= P_CHK;
          end
          P_CHK: begin
            pState_q <= P_IDLE;
            if (frameOk_d) begin
              timing_q <= val_q[6:0];
              start_q  <= 1'b1;
            end else begin
              cmdErr_q <= 1'b1;
            end
          end
          default: pState_q <= P_IDLE;
        endcase
      end else if (pState_q != P_IDLE) begin
        if (toCnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          pState_q <= P_IDLE;
          toCnt_q  <= '0;
          cmdErr_q <= 1'b1;
        end else begin
          toCnt_q <= toCnt_q + TO_W'(1);
        end
      end else begin
        toCnt_q <= '0;
      end
    end
  end

  assign timing  = timing_q;
  assign start   = start_q;
  assign abort   = abort_q;
  assign cmd_err = cmdErr_q;

endmodule

// File: doc/game_cmd_uart_rx.md
# game_cmd_uart_rx

Serial command front-end for the countdown audio stage. Receives 8N1 UART bytes from the host PC and parses start/abort command frames. Delivers a validated total game time (seconds) with a one-cycle start strobe to the tick/tock generator, which consumes `timing` and `start` in place of a push-button. Rejects malformed or out-of-range frames, and reports each rejection with an error strobe.

## Interface
- `CLKS_PER_BIT`, default 10416: `basys_clk` cycles per UART bit (100 MHz / 9600 baud).
- `MAX_TIME`, default 99: largest accepted game time in seconds; legal range is 1..MAX_TIME.
- `TIMEOUT_CYC`, default 50000000: maximum idle cycles between bytes of one frame before the parser discards the partial frame.

Ports:
- `basys_clk` in, 1: system clock, 100 MHz.
- `rst_n` in, 1: asynchronous active-low reset.
- `rx` in, 1: UART receive line, asynchronous, idle high.
- `game_active` in, 1: high while the countdown stage is playing.
- `timing` out, 7: last accepted game time in seconds.
- `start` out, 1: one-cycle pulse; new `timing` is valid on the same cycle.
- `abort` out, 1: one-cycle pulse requesting the countdown stop.
- `cmd_err` out, 1: one-cycle pulse on any rejected byte or frame.

## Operation
- Reset values: `timing`=0, `start`=0, `abort`=0, `cmd_err`=0. Receiver and parser go to IDLE, all counters clear, and synchronizer flops reset to 1.
- `rx` passes through a 2-flop synchronizer; all logic below uses the synchronized value.
- Receiver FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE → R_START when the synchronized `rx` is 0.
  - R_START: wait CLKS_PER_BIT/2 cycles, then resample. If `rx` is 0, go to R_DATA; if 1, treat it as a glitch and return to R_IDLE with no error.
  - R_DATA: sample 8 bits, LSB first, every CLKS_PER_BIT cycles.
  - R_STOP: sample once after CLKS_PER_BIT cycles. Stop=1 produces an internal `byte_valid` pulse for one cycle. Stop=0 is a framing error: `cmd_err` pulses, the byte is dropped, and the parser is forced to P_IDLE.
  - Either outcome returns to R_IDLE.
- Parser FSM states: P_IDLE, P_VAL, P_CHK. It advances only on `byte_valid`.
  - P_IDLE:
    - 0x53 ('S') → P_VAL.
    - 0x58 ('X') → `abort` pulse, stay in P_IDLE.
    - Any other byte → `cmd_err` pulse, stay in P_IDLE.
  - P_VAL: latch the byte into an internal `val`, → P_CHK. No range check happens here.
  - P_CHK: the frame is accepted when all of the following hold:
    - byte == (0x53 XOR `val`);
    - 1 ≤ `val` ≤ MAX_TIME;
    - `game_active` is 0 on that cycle.
  - Accept: `timing` ← `val`[6:0] and `start` pulses. Otherwise `cmd_err` pulses and `timing` is unchanged. Both outcomes go to P_IDLE.
- Inter-byte timeout:
  - A counter clears on every `byte_valid` and increments while the parser is in P_VAL or P_CHK.
  - Reaching TIMEOUT_CYC returns the parser to P_IDLE with a `cmd_err` pulse.
  - The counter does not run in P_IDLE.
- 'X' is honoured only in P_IDLE. Inside a frame, 0x58 is treated as data or checksum.

## Timing
- `byte_valid` fires 1 cycle after the stop-bit sample. Parser outputs (`start`, `abort`, `cmd_err`, `timing`) register 1 cycle after `byte_valid`.
- End-to-end latency from the stop-bit centre to `start` is 2 cycles.
- All pulses are exactly 1 cycle wide, and `start` and `cmd_err` are never high together.
- Stop-bit framing error and timeout expiry on the same cycle produce a single `cmd_err` pulse.
- `timing` holds its value indefinitely. `start` is not re-issued without a new frame.
- Asserting `rst_n` mid-byte or mid-frame abandons all progress. After reset release, a new start bit is required; a line that is already low at release is detected as a start bit.
- Counter widths: bit counter ≥ $clog2(CLKS_PER_BIT+1); timeout counter ≥ $clog2(TIMEOUT_CYC+1).

## Test plan
Benches override `CLKS_PER_BIT`=16 and `TIMEOUT_CYC`=2000.

1. Send frame 0x53, 0x19, 0x4A with `game_active`=0 → `timing`=25 and one `start` pulse 2 cycles after the last stop-bit sample; `cmd_err` stays 0.
2. Send 0x53, 0x19, 0x4B (bad checksum) → one `cmd_err` pulse, no `start`, `timing` keeps its previous value. Repeat with value 0x00 and with value 0x64 (checksums correct) → `cmd_err` each time.
3. Send a valid frame 0x53, 0x0A, 0x59 with `game_active`=1 → `cmd_err` and no `start`. Then send 0x58 → one `abort` pulse.
4. Send 0x53 and then stay idle for 2000 cycles → `cmd_err` at timeout. A subsequent valid frame for value 10 is accepted → `timing`=10 with `start`.
5. Send a byte with stop bit 0 mid-frame → `cmd_err` and parser in P_IDLE. A 5-cycle low glitch on `rx` → no byte, no error.
6. Assert `rst_n` during the P_CHK byte's data bits → all outputs 0. Release reset and send a valid frame → accepted normally.
